// File: rtl/gauss_window_3x3_pkg.sv
// Shared constants for the style-pipeline 3x3 neighbourhood stage.
// Holds the default pixel width, the window size and the default image geometry.
package gauss_window_3x3_pkg;

   localparam int PIX_DW    = 8;
   localparam int K         = 3;
   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

endpackage

// File: rtl/gauss_window_3x3_if.sv
// Pixel-in / window-out bundle between the raster source, the window generator
// and the downstream blur kernel.
// The master side drives pixels and the slave side produces the 3x3 window.
interface gauss_window_3x3_if
   import gauss_window_3x3_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int DW    = PIX_DW
);

   localparam int CXW = $clog2(IMG_W);
   localparam int CYW = $clog2(IMG_H);

   logic           iDVAL;
   logic           iSOF;
   logic [DW-1:0]  iGrey;

   logic           oDVAL;
   logic [DW-1:0]  og00, og01, og02;
   logic [DW-1:0]  og10, og11, og12;
   logic [DW-1:0]  og20, og21, og22;
   logic [CXW-1:0] oCX;
   logic [CYW-1:0] oCY;

   modport master (
      output iDVAL, iSOF, iGrey,
      input  oDVAL, og00, og01, og02, og10, og11, og12, og20, og21, og22, oCX, oCY
   );

   modport slave (
      input  iDVAL, iSOF, iGrey,
      output oDVAL, og00, og01, og02, og10, og11, og12, og20, og21, og22, oCX, oCY
   );

endinterface

// File: rtl/gauss_window_3x3_line_delay.sv
// Fixed-length pixel delay that advances only when enabled.
// Output is the pixel written DEPTH enabled cycles earlier; contents are never reset.
module line_delay
   import gauss_window_3x3_pkg::*;
#(
   parameter int DEPTH = IMG_W_DEF,
   parameter int DW    = PIX_DW
) (
   input  logic          iCLK,
   input  logic          iEN,
   input  logic [DW-1:0] iD,
   output logic [DW-1:0] oQ
);

   logic [DW-1:0] stage [DEPTH];

   // Shift the whole line one slot on every enabled clock
   always_ff @(posedge iCLK) begin
      if (iEN) begin
         stage[0] <= iD;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign oQ = stage[DEPTH-1];

endmodule

// File: rtl/gauss_window_3x3.sv
// Streaming 3x3 neighbourhood generator feeding the Gaussian blur kernel.
// Two line delays supply the previous two lines; a registered 3x3 window plus
// centre coordinates are produced one clock after each accepted pixel.
module gauss_window_3x3
   import gauss_window_3x3_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int DW    = PIX_DW
) (
   input logic               iCLK,
   input logic               iRST_N,
   gauss_window_3x3_if.slave win
);

   localparam int CXW = $clog2(IMG_W);
   localparam int CYW = $clog2(IMG_H);

   localparam logic [CXW-1:0] LAST_COL  = CXW'(IMG_W - 1);
   localparam logic [CYW-1:0] LAST_ROW  = CYW'(IMG_H - 1);
   localparam logic [CXW-1:0] FIRST_COL = CXW'(K - 1);
   localparam logic [CYW-1:0] FIRST_ROW = CYW'(K - 1);

   logic [CXW-1:0] colCnt;
   logic [CYW-1:0] rowCnt;
   logic [CXW-1:0] curCol;
   logic [CYW-1:0] curRow;
   logic           accept;
   logic           posValid;
   logic           lineEn;
   logic [DW-1:0]  lb1Q;
   logic [DW-1:0]  lb2Q;
   logic [DW-1:0]  tap [K][K];
   logic           winValid;
   logic [CXW-1:0] centreX;
   logic [CYW-1:0] centreY;

   assign accept = win.iDVAL;
   assign lineEn = accept & iRST_N;

   // Position of the incoming pixel: start of frame forces the origin
   always_comb begin
      curCol = colCnt;
      curRow = rowCnt;
      if (win.iSOF) begin
         curCol = '0;
         curRow = '0;
      end
      posValid = (curCol >= FIRST_COL) && (curRow >= FIRST_ROW);
   end

   line_delay #(.DEPTH(IMG_W), .DW(DW)) uLine1 (
      .iCLK (iCLK),
      .iEN  (lineEn),
      .iD   (win.iGrey),
      .oQ   (lb1Q)
   );

   line_delay #(.DEPTH(IMG_W), .DW(DW)) uLine2 (
      .iCLK (iCLK),
      .iEN  (lineEn),
      .iD   (lb1Q),
      .oQ   (lb2Q)
   );

   // Raster counters advance past the accepted pixel, wrapping at line and frame end
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         colCnt <= '0;
         rowCnt <= '0;
      end else if (accept) begin
         if (curCol == LAST_COL) begin
            colCnt <= '0;
            rowCnt <= (curRow == LAST_ROW) ? '0 : curRow + 1'b1;
         end else begin
            colCnt <= curCol + 1'b1;
            rowCnt <= curRow;
         end
      end
   end

   // Window shifts left one column per accept; new column comes from the line delays
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               tap[i][j] <= '0;
            end
         end
      end else if (accept) begin
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) begin
               tap[i][j] <= tap[i][j+1];
            end
         end
         tap[0][K-1] <= lb2Q;
         tap[1][K-1] <= lb1Q;
         tap[2][K-1] <= win.iGrey;
      end
   end

   // Valid pulse and centre coordinates for windows fully inside the image
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         winValid <= 1'b0;
         centreX  <= '0;
         centreY  <= '0;
      end else begin
         winValid <= accept && posValid;
         if (accept && posValid) begin
            centreX <= curCol - 1'b1;
            centreY <= curRow - 1'b1;
         end
      end
   end

   assign win.oDVAL = winValid;
   assign win.oCX   = centreX;
   assign win.oCY   = centreY;
   assign win.og00  = tap[0][0];
   assign win.og01  = tap[0][1];
   assign win.og02  = tap[0][2];
   assign win.og10  = tap[1][0];
   assign win.og11  = tap[1][1];
   assign win.og12  = tap[1][2];
   assign win.og20  = tap[2][0];
   assign win.og21  = tap[2][1];
   assign win.og22  = tap[2][2];

endmodule

// File: tb/tb_gauss_window_3x3.sv
// Self-checking bench for gauss_window_3x3 on a 4x4 image.
// Reference model keeps the accepted pixel stream and a linear raster index;
// expected taps are looked up by stream age, not by mimicking the registers.
module tb_gauss_window_3x3;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rstN;

   always #5 clk = ~clk;

   gauss_window_3x3_if #(.IMG_W(W), .IMG_H(H), .DW(DW)) bus ();

   gauss_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
      .iCLK   (clk),
      .iRST_N (rstN),
      .win    (bus)
   );

   int checks    = 0;
   int failures  = 0;
   int dutPulses = 0;

   // Reference model state
   int hist[$];
   int rasterIdx   = 0;
   int accSinceRst = 0;
   bit expValid    = 1'b0;
   int expCx       = 0;
   int expCy       = 0;

   // Safety net in case the run never reaches its summary
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] obsTap(input int i, input int j);
      case (i*3 + j)
         0:       return bus.og00;
         1:       return bus.og01;
         2:       return bus.og02;
         3:       return bus.og10;
         4:       return bus.og11;
         5:       return bus.og12;
         6:       return bus.og20;
         7:       return bus.og21;
         default: return bus.og22;
      endcase
   endfunction

   // Compare every output against the model after each clock
   task automatic checkAll();
      int n;
      int age;
      int k;
      n = hist.size();
      checkOutput("oDVAL", {31'd0, bus.oDVAL}, {31'd0, expValid});
      if (bus.oDVAL === 1'b1) dutPulses++;
      checkOutput("oCX", 32'(bus.oCX), expCx);
      checkOutput("oCY", 32'(bus.oCY), expCy);
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            age = 2 - j;
            if (age >= accSinceRst) begin
               checkOutput($sformatf("og%0d%0d", i, j), 32'(obsTap(i, j)), 0);
            end else begin
               k = n - 1 - age - (2 - i) * W;
               if (k >= 0) checkOutput($sformatf("og%0d%0d", i, j), 32'(obsTap(i, j)), hist[k]);
            end
         end
      end
   endtask

   // Drive one clock of inputs, advance the model, then check outputs
   task automatic applyStimulus(input bit dv, input bit sof, input int g, input bit rn);
      int r;
      int c;
      bus.iDVAL = dv;
      bus.iSOF  = sof;
      bus.iGrey = g[DW-1:0];
      rstN      = rn;
      @(posedge clk);
      if (!rn) begin
         rasterIdx   = 0;
         accSinceRst = 0;
         expValid    = 1'b0;
         expCx       = 0;
         expCy       = 0;
      end else begin
         expValid = 1'b0;
         if (dv) begin
            if (sof) rasterIdx = 0;
            r = rasterIdx / W;
            c = rasterIdx % W;
            hist.push_back(g & 255);
            accSinceRst++;
            if (r >= 2 && c >= 2) begin
               expValid = 1'b1;
               expCx    = c - 1;
               expCy    = r - 1;
            end
            rasterIdx = (rasterIdx + 1) % (W * H);
         end
      end
      #1;
      checkAll();
   endtask

   task automatic checkWindow(input int base);
      checkOutput("win_oDVAL", {31'd0, bus.oDVAL}, 1);
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("win_og%0d%0d", i, j), 32'(obsTap(i, j)), base + 16*i + j);
         end
      end
      checkOutput("win_oCX", 32'(bus.oCX), 1);
      checkOutput("win_oCY", 32'(bus.oCY), 1);
   endtask

   // Stream one frame of 16*r+c+base, optionally stalling before pixel (2,2)
   task automatic runFrame(input int base, input int stall22, input bit checkWin);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == 2 && c == 2) begin
               repeat (stall22) applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 255)), 1'b1);
            end
            applyStimulus(1'b1, (r == 0 && c == 0), base + 16*r + c, 1'b1);
            if (checkWin && r == 2 && c == 2) checkWindow(base);
            if (checkWin && r == H-1 && c == W-1) begin
               checkOutput("last_oDVAL", {31'd0, bus.oDVAL}, 1);
               checkOutput("last_og22", 32'(bus.og22), base + 'h33);
               checkOutput("last_oCX", 32'(bus.oCX), 2);
               checkOutput("last_oCY", 32'(bus.oCY), 2);
            end
         end
      end
   endtask

   initial begin
      int p0;
      bus.iDVAL = 1'b0;
      bus.iSOF  = 1'b0;
      bus.iGrey = '0;
      rstN      = 1'b0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      checkOutput("rst_oDVAL", {31'd0, bus.oDVAL}, 0);
      checkOutput("rst_og11", 32'(bus.og11), 0);

      // Basic window and border gating
      p0 = dutPulses;
      runFrame(0, 0, 1'b1);
      checkOutput("basic_pulses", dutPulses - p0, 4);

      // Idle cycles before (2,2)
      p0 = dutPulses;
      runFrame(0, 3, 1'b1);
      checkOutput("stall_pulses", dutPulses - p0, 4);

      // Two back-to-back frames
      p0 = dutPulses;
      runFrame(0, 0, 1'b0);
      runFrame('h80, 0, 1'b1);
      checkOutput("wrap_pulses", dutPulses - p0, 8);

      // Start of frame arriving in place of pixel (3,1)
      p0 = dutPulses;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r < 3 || c < 1) applyStimulus(1'b1, (r == 0 && c == 0), 16*r + c, 1'b1);
         end
      end
      runFrame(0, 0, 1'b1);
      checkOutput("sof_pulses", dutPulses - p0, 6);

      // Reset after pixel (2,3), then a clean frame
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < W; c++) begin
            applyStimulus(1'b1, (r == 0 && c == 0), 16*r + c, 1'b1);
         end
      end
      applyStimulus(1'b1, 1'b0, 'h55, 1'b0);
      checkOutput("mrst_oDVAL", {31'd0, bus.oDVAL}, 0);
      checkOutput("mrst_og22", 32'(bus.og22), 0);
      checkOutput("mrst_og00", 32'(bus.og00), 0);
      checkOutput("mrst_oCX", 32'(bus.oCX), 0);
      checkOutput("mrst_oCY", 32'(bus.oCY), 0);
      p0 = dutPulses;
      runFrame(0, 0, 1'b1);
      checkOutput("mrst_pulses", dutPulses - p0, 4);

      // Randomized traffic: random pixels, idles, frame starts and resets
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 30) == 0),
                       int'($urandom_range(0, 255)),
                       ($urandom_range(0, 199) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gauss_window_3x3.md
Name: gauss_window_3x3

Overview:
Streaming 3x3 neighbourhood generator that sits directly upstream of the 3x3 Gaussian blur kernel in the style pipeline. It accepts one raster-order grey pixel per valid cycle. It buffers the two previous image lines and presents a registered 3x3 window plus a valid flag. The nine window outputs map one-to-one onto the blur kernel's nine pixel inputs.

Parameters:
- IMG_W, 640, active pixels per line (>= 3).
- IMG_H, 480, active lines per frame (>= 3).
- DW, 8, grey pixel width.

Ports:
- iCLK  in  1  system clock; all state updates on its rising edge.
- iRST_N  in  1  synchronous, active-low reset.
- iDVAL  in  1  input pixel valid; a pixel is accepted on every clock with iDVAL=1.
- iSOF  in  1  start of frame; qualified by iDVAL and marks the accepted pixel as (row 0, col 0).
- iGrey  in  DW  input grey pixel.
- oDVAL  out  1  window valid.
- og00, og01, og02, og10, og11, og12, og20, og21, og22  out  DW each  window taps; first digit is row (0 = oldest line), second digit is column (0 = oldest column).
- oCX  out  $clog2(IMG_W)  column of the window centre.
- oCY  out  $clog2(IMG_H)  row of the window centre.

Behaviour:
- Reset: when iRST_N=0 at a clock edge, the following clear to 0: col/row counters, all nine taps, oDVAL, oCX and oCY. Line-buffer contents are don't-care and are not reset. Reset applies mid-frame and overrides iDVAL.
- Accept: when iDVAL=1, the accepted pixel is p(r,c). r and c are taken from the counters, or forced to 0,0 when iSOF=1.
- Counter update on accept:
  - c advances to c+1.
  - At c=IMG_W-1, c wraps to 0 and r advances to r+1.
  - At r=IMG_H-1 together with c=IMG_W-1, both wrap to 0.
  - When iSOF=1, the next position is (0,1).
- Line buffers: two cascaded IMG_W-deep shift delays, each shifting only on accept.
  - Line buffer 1 output = p(r-1,c).
  - Line buffer 2 output = p(r-2,c).
- Window shift on accept:
  - Each row's columns shift left (x0 <- x1 <- x2).
  - New column loads as og02=p(r-2,c), og12=p(r-1,c), og22=p(r,c).
- Latency: the window is registered. On the clock after p(r,c) is accepted, the taps hold rows r-2..r and columns c-2..c, and the centre is p(r-1,c-1).
- oDVAL: equals 1 on the clock after an accept with r>=2 and c>=2. It is 0 in every other cycle, including any cycle following iDVAL=0.
- oCX/oCY:
  - Registered as c-1 and r-1 on accepts where oDVAL will be 1.
  - Otherwise hold their previous value.
- Stall: iDVAL=0 freezes counters, line buffers and taps, and drives oDVAL=0 on the next clock. Any number of idle cycles is allowed, including within a line.
- Borders:
  - No padding: rows 0-1 and columns 0-1 of every line produce no valid window.
  - Each frame yields (IMG_W-2)*(IMG_H-2) valid windows.
  - Taps at a line start hold stale previous-line data; this is legal because oDVAL is gated.
- iSOF mid-frame: immediately resynchronises the counters. Data left in the line buffers from the aborted frame is masked because rows 0-1 are not valid.
- No backpressure: the downstream kernel is combinational and always ready.

Decomposition:
- Shared pipeline package holds:
  - DW.
  - The window size constant K=3.
  - Default IMG_W/IMG_H.
- One sub-module, line_delay: parameters DEPTH and DW; ports iCLK, iEN, iD, oQ; fixed-length shift register or circular RAM with a wrapping pointer. It is instantiated twice.
- Counters, window registers and valid/coordinate logic live in the top module.

Test Plan:
All scenarios use IMG_W=4, IMG_H=4 and pixel value 16*r+c unless stated otherwise.
- Basic window: continuous frame with iSOF on pixel 0. One clock after pixel (2,2) is accepted: oDVAL=1, og00=0x00, og01=0x01, og02=0x02, og10=0x10, og11=0x11, og12=0x12, og20=0x20, og21=0x21, og22=0x22, oCX=1, oCY=1. Exactly 4 oDVAL pulses per frame; the last pulse shows og22=0x33 with oCX=2, oCY=2.
- Border gating: during pixels (0,x), (1,x), (2,0) and (2,1), oDVAL stays 0 throughout.
- Stalls: insert 3 idle cycles between (2,1) and (2,2). oDVAL=0 and taps are frozen during the idle cycles; the window after (2,2) matches the basic-window scenario exactly.
- Frame wrap: two back-to-back frames, second frame pixel = 0x80+16*r+c, no idle cycles. After the second frame's (2,2): og00=0x80 and og22=0xA2; 8 valid windows in total.
- Mid-frame iSOF: assert iSOF at frame-1 pixel (3,1), then stream a full frame. No oDVAL until the new (2,2). That window matches the basic-window values.
- Reset mid-frame: iRST_N=0 for 1 clock after (2,3). The next clock shows all taps=0, oDVAL=0, oCX=0, oCY=0. Streaming a full frame (iSOF on pixel 0) afterwards gives the basic-window results.
